// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction memory,
// absorbs decode stalls in a one-entry hold buffer. Optional: FETCH_MISALIGN_CHECK_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic            fault
);

    logic [XLEN-1:0] pc_q;
    logic            req_valid_q;
    logic [XLEN-1:0] req_pc_q;
    logic            hold_valid_q;
    logic [XLEN-1:0] hold_pc_q;
    logic [XLEN-1:0] hold_instr_q;
    logic [XLEN-1:0] target;
    logic            issue;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q;
    logic misaligned;

    always_comb begin
        target     = redirect_pc;
        misaligned = redirect && (redirect_pc[1:0] != 2'b00);
        // An aligned redirect is the only way out of the fault state short of reset.
        issue      = !rst && (redirect ? !misaligned : (!stall && !fault_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (redirect) begin
            fault_q <= misaligned;
        end
    end

    assign fault = fault_q;
`else
    logic unused_redirect_lsb;

    always_comb begin
        target = {redirect_pc[XLEN-1:2], 2'b00};
        issue  = !rst && (redirect || !stall);
    end

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign fault               = 1'b0;
`endif

    assign imem_en   = issue;
    assign imem_addr = redirect ? target : pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            req_valid_q  <= 1'b0;
            hold_valid_q <= 1'b0;
        end else begin
            req_valid_q <= issue;
            if (issue) begin
                pc_q     <= imem_addr + XLEN'(4);
                req_pc_q <= imem_addr;
            end
            // Redirect flushes the hold; a stalled response is captured once, then kept.
            if (redirect) begin
                hold_valid_q <= 1'b0;
            end else if (stall) begin
                if (!hold_valid_q && req_valid_q) begin
                    hold_valid_q <= 1'b1;
                    hold_pc_q    <= req_pc_q;
                    hold_instr_q <= imem_rdata;
                end
            end else begin
                hold_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        if (hold_valid_q) begin
            out_valid = 1'b1;
            out_pc    = hold_pc_q;
            out_instr = hold_instr_q;
        end else begin
            out_valid = req_valid_q;
            out_pc    = req_pc_q;
            out_instr = imem_rdata;
        end
        if (redirect) begin
            out_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations, then
// randomized reset/stall/redirect traffic checked against a transaction-level model.
module tb_fetch_stage;

    localparam logic [31:0] ResetPc = 32'h0000_0100;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MisChk = 1'b1;
`else
    localparam bit MisChk = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fault;

    int checks = 0;
    int failures = 0;

    fetch_stage #(
        .RESET_PC(ResetPc),
        .XLEN    (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h0050_0093 : (a ^ 32'h1357_9BDF);
    endfunction

    // Synchronous memory; garbage on cycles without a read strobe.
    always @(posedge clk) imem_rdata <= imem_en ? mem_word(imem_addr) : $urandom;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the instruction currently presented to decode, the next sequential PC, fault.
    bit          model_ok = 1'b0;
    bit          m_pv = 1'b0;
    logic [31:0] m_ppc = 32'h0;
    logic [31:0] m_npc = 32'h0;
    bit          m_f = 1'b0;

    function automatic bit mis(input logic [31:0] a);
        return MisChk && (a[1:0] != 2'b00);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_ok <= 1'b1;
            m_pv     <= 1'b0;
            m_npc    <= ResetPc;
            m_f      <= 1'b0;
        end else if (redirect) begin
            if (mis(redirect_pc)) begin
                m_f  <= 1'b1;
                m_pv <= 1'b0;
            end else begin
                m_f   <= 1'b0;
                m_pv  <= 1'b1;
                m_ppc <= redirect_pc & ~32'h3;
                m_npc <= (redirect_pc & ~32'h3) + 32'h4;
            end
        end else if (!stall && !m_f) begin
            m_pv  <= 1'b1;
            m_ppc <= m_npc;
            m_npc <= m_npc + 32'h4;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            bit          e_en;
            bit          e_valid;
            logic [31:0] e_addr;
            e_en    = !rst && (redirect ? !mis(redirect_pc) : (!stall && !m_f));
            e_addr  = redirect ? (redirect_pc & ~32'h3) : m_npc;
            e_valid = m_pv && !redirect;
            chk("imem_en", 32'(imem_en), 32'(e_en));
            if (e_en) chk("imem_addr", imem_addr, e_addr);
            chk("out_valid", 32'(out_valid), 32'(e_valid));
            if (e_valid) begin
                chk("out_pc", out_pc, m_ppc);
                chk("out_instr", out_instr, mem_word(m_ppc));
            end
            chk("fault", 32'(fault), 32'(m_f));
        end
    end

    task automatic cyc(input bit r, input bit s, input bit rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst         = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        @(negedge clk);
    endtask

    initial begin
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("lit_reset_valid", 32'(out_valid), 32'h0);
        chk("lit_reset_en", 32'(imem_en), 32'h0);
        cyc(0, 0, 0, 0);
        chk("lit_first_en", 32'(imem_en), 32'h1);
        chk("lit_first_addr", imem_addr, 32'h100);
        cyc(0, 0, 0, 0);
        chk("lit_first_valid", 32'(out_valid), 32'h1);
        chk("lit_first_pc", out_pc, 32'h100);
        chk("lit_first_instr", out_instr, 32'h0050_0093);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            chk("lit_stall_en", 32'(imem_en), 32'h0);
            chk("lit_stall_pc", out_pc, 32'h104);
            chk("lit_stall_instr", out_instr, 32'h1357_9ADB);
        end
        cyc(0, 0, 0, 0);
        chk("lit_release_pc", out_pc, 32'h104);
        chk("lit_release_addr", imem_addr, 32'h108);
        cyc(0, 0, 0, 0);
        chk("lit_after_release_pc", out_pc, 32'h108);
        cyc(0, 0, 1, 32'h200);
        chk("lit_redir_squash", 32'(out_valid), 32'h0);
        chk("lit_redir_addr", imem_addr, 32'h200);
        cyc(0, 0, 0, 0);
        chk("lit_redir_pc", out_pc, 32'h200);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("lit_hold_pc", out_pc, 32'h204);
        cyc(0, 1, 1, 32'h300);
        chk("lit_hold_redir_valid", 32'(out_valid), 32'h0);
        cyc(0, 0, 0, 0);
        chk("lit_hold_redir_valid2", 32'(out_valid), 32'h1);
        chk("lit_hold_redir_pc", out_pc, 32'h300);
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0);
        chk("lit_wrap_pc0", out_pc, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0);
        chk("lit_wrap_pc1", out_pc, 32'h0);
        cyc(0, 0, 1, 32'h202);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("lit_mis_en", 32'(imem_en), 32'h0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0);
            chk("lit_mis_fault", 32'(fault), 32'h1);
            chk("lit_mis_en_hold", 32'(imem_en), 32'h0);
            chk("lit_mis_valid", 32'(out_valid), 32'h0);
        end
        cyc(0, 0, 1, 32'h300);
        chk("lit_mis_clear_en", 32'(imem_en), 32'h1);
        cyc(0, 0, 0, 0);
        chk("lit_mis_clear_fault", 32'(fault), 32'h0);
        chk("lit_mis_clear_pc", out_pc, 32'h300);
`else
        chk("lit_mis_addr", imem_addr, 32'h200);
        cyc(0, 0, 0, 0);
        chk("lit_mis_pc", out_pc, 32'h200);
        chk("lit_mis_fault", 32'(fault), 32'h0);
`endif

        for (int i = 0; i < 4000; i++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 7) == 0), rpc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
